// File: rtl/hazard_stall_controller_pkg.sv
// Shared types for the hazard stall controller.
// Optional perf counters: HAZARD_PERF_CNT_EN.
package hazard_pkg;

  localparam int ALU_LAT_DEF  = 2;
  localparam int LOAD_LAT_DEF = 3;
  localparam int REM_W        = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [4:0]       rd;
    logic [REM_W-1:0] rem;
  } sb_entry_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// ID-stage bundle and stall/flush controls.
// HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
interface hazard_stall_controller_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_is_load;
  logic       ex_flush_req;
  logic       pc_hold;
  logic       if_id_hold;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic [1:0] busy_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_rs1_used, id_rs2_used,
    output id_rd, id_regwrite, id_is_load,
    output ex_flush_req,
    input  pc_hold, if_id_hold, if_id_flush,
    input  id_ex_bubble, busy_state
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles, flush_cycles
`endif
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_rs1_used, id_rs2_used,
    input  id_rd, id_regwrite, id_is_load,
    input  ex_flush_req,
    output pc_hold, if_id_hold, if_id_flush,
    output id_ex_bubble, busy_state
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles, flush_cycles
`endif
  );
endinterface

// File: rtl/hazard_stall_controller_scoreboard.sv
// Age-indexed in-flight destination scoreboard.
// Flags a RAW hazard until the result is forwardable.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int ALU_LAT  = ALU_LAT_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int MAX_LAT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_id_valid,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic       i_rs1_used,
  input  logic       i_rs2_used,
  input  logic [4:0] i_rd,
  input  logic       i_regwrite,
  input  logic       i_is_load,
  input  logic       i_issue,
  input  logic       i_flush,
  output logic       o_hazard
);

  sb_entry_t r_slot [MAX_LAT];
  sb_entry_t w_age  [MAX_LAT-1];
  sb_entry_t w_new;
  logic      w_match;

  // Entry for the instruction entering EX1 this cycle
  always_comb begin
    w_new = '0;
    if (i_issue && i_regwrite && i_rd != 5'd0) begin
      w_new.valid = 1'b1;
      w_new.rd    = i_rd;
      w_new.rem   = i_is_load ? REM_W'(LOAD_LAT - 1)
                              : REM_W'(ALU_LAT - 1);
    end
  end

  // Age each slot; a mispredict kills the EX1 entry
  always_comb begin
    for (int k = 0; k < MAX_LAT-1; k++) begin
      logic [REM_W-1:0] rem_n;
      rem_n = (r_slot[k].rem != '0) ? r_slot[k].rem - 1'b1 : '0;
      w_age[k].rd    = r_slot[k].rd;
      w_age[k].rem   = rem_n;
      w_age[k].valid = r_slot[k].valid && (rem_n != '0);
    end
    if (i_flush) w_age[0].valid = 1'b0;
  end

  // Match ID sources against entries not yet forwardable
  always_comb begin
    w_match = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (r_slot[k].valid && r_slot[k].rem != '0) begin
        if (i_rs1_used && i_rs1 != 5'd0 &&
            r_slot[k].rd == i_rs1) w_match = 1'b1;
        if (i_rs2_used && i_rs2 != 5'd0 &&
            r_slot[k].rd == i_rs2) w_match = 1'b1;
      end
    end
    o_hazard = i_id_valid && w_match;
  end

  // Shift register of in-flight producers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MAX_LAT; k++) r_slot[k] <= '0;
    end else begin
      r_slot[0] <= w_new;
      for (int k = 1; k < MAX_LAT; k++) r_slot[k] <= w_age[k-1];
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 2-cycle-ALU pipeline.
// Define HAZARD_PERF_CNT_EN for stall/flush cycle counters.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int ALU_LAT      = ALU_LAT_DEF,
  parameter int LOAD_LAT     = LOAD_LAT_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_LAT      = 3
) (
  input logic clk,
  input logic reset,
  hazard_stall_controller_if.slave bus
);

  localparam int CNT_W =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(FLUSH_CYCLES - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hazard;
  logic             w_in_flush;
  logic             w_issue;
  logic             w_hold;
  logic             w_flush;

  assign w_in_flush = (r_state == ST_FLUSH);
  assign w_issue    = bus.id_valid && !w_in_flush &&
                      !w_hazard && !bus.ex_flush_req;
  assign w_hold     = w_hazard && !w_in_flush &&
                      !bus.ex_flush_req;
  assign w_flush    = bus.ex_flush_req || w_in_flush;

  hazard_scoreboard #(
    .ALU_LAT  (ALU_LAT),
    .LOAD_LAT (LOAD_LAT),
    .MAX_LAT  (MAX_LAT)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_id_valid (bus.id_valid),
    .i_rs1      (bus.id_rs1),
    .i_rs2      (bus.id_rs2),
    .i_rs1_used (bus.id_rs1_used),
    .i_rs2_used (bus.id_rs2_used),
    .i_rd       (bus.id_rd),
    .i_regwrite (bus.id_regwrite),
    .i_is_load  (bus.id_is_load),
    .i_issue    (w_issue),
    .i_flush    (bus.ex_flush_req),
    .o_hazard   (w_hazard)
  );

  // Sequencing FSM: flush beats hazard
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_FLUSH: begin
          if (bus.ex_flush_req) begin
            r_cnt <= CNT_LOAD;
          end else if (r_cnt == '0) begin
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          if (bus.ex_flush_req) begin
            r_state <= ST_FLUSH;
            r_cnt   <= CNT_LOAD;
          end else if (w_hazard) begin
            r_state <= ST_STALL;
          end else begin
            r_state <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign bus.pc_hold      = w_hold;
  assign bus.if_id_hold   = w_hold;
  assign bus.if_id_flush  = w_flush;
  assign bus.id_ex_bubble = w_hazard || w_flush;
  assign bus.busy_state   = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating hold/flush cycle counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_hold && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cycles = r_stall_cnt;
  assign bus.flush_cycles = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller.
// Build with HAZARD_PERF_CNT_EN to also check the counters.
module tb_hazard_stall_controller;
  import hazard_pkg::*;

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  hazard_stall_controller_if bus();

  hazard_stall_controller u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input bit v,
                     input logic [4:0] rs1, input bit u1,
                     input logic [4:0] rs2, input bit u2,
                     input logic [4:0] rd, input bit rw,
                     input bit ld, input bit fl);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs1_used  = u1;
    bus.id_rs2       = rs2;
    bus.id_rs2_used  = u2;
    bus.id_rd        = rd;
    bus.id_regwrite  = rw;
    bus.id_is_load   = ld;
    bus.ex_flush_req = fl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check outputs mid-cycle, then advance one clock
  task automatic cyc(input string tag, input bit h,
                     input bit f, input bit b,
                     input logic [1:0] st);
    @(negedge clk);
    chk({tag, ".pc_hold"}, 32'(bus.pc_hold), 32'(h));
    chk({tag, ".ifid_hold"}, 32'(bus.if_id_hold), 32'(h));
    chk({tag, ".ifid_flush"}, 32'(bus.if_id_flush), 32'(f));
    chk({tag, ".bubble"}, 32'(bus.id_ex_bubble), 32'(b));
    chk({tag, ".state"}, 32'(bus.busy_state), 32'(st));
    tick();
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle();
    tick();
    cyc("rst", 0, 0, 0, 0);
    reset = 1'b0;

    // ALU producer then dependent: one stall cycle
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc("alu.c0", 0, 0, 0, 0);
    drv(1, 5, 1, 0, 0, 6, 1, 0, 0);
    cyc("alu.c1", 1, 0, 1, 0);
    cyc("alu.c2", 0, 0, 0, 1);
    idle();
    cyc("alu.c3", 0, 0, 0, 0);
    cyc("alu.c4", 0, 0, 0, 0);

    // Load-use: two stall cycles on rs2
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0);
    cyc("ld.c0", 0, 0, 0, 0);
    drv(1, 0, 0, 7, 1, 0, 0, 0, 0);
    cyc("ld.c1", 1, 0, 1, 0);
    cyc("ld.c2", 1, 0, 1, 1);
    cyc("ld.c3", 0, 0, 0, 1);
    idle();
    cyc("ld.c4", 0, 0, 0, 0);

    // Independent instruction after a load
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0);
    cyc("ind.c0", 0, 0, 0, 0);
    drv(1, 8, 1, 8, 1, 0, 0, 0, 0);
    cyc("ind.c1", 0, 0, 0, 0);
    idle();
    cyc("ind.c2", 0, 0, 0, 0);
    cyc("ind.c3", 0, 0, 0, 0);

    // x0 producer, and an unused matching source
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("x0.c0", 0, 0, 0, 0);
    drv(1, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("x0.c1", 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc("unu.c0", 0, 0, 0, 0);
    drv(1, 5, 0, 9, 1, 0, 0, 0, 0);
    cyc("unu.c1", 0, 0, 0, 0);
    idle();
    cyc("unu.c2", 0, 0, 0, 0);

    // Mispredict pulse kills the in-EX1 load
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0);
    cyc("mis.c0", 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("mis.c1", 0, 1, 1, 0);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0);
    cyc("mis.c2", 0, 1, 1, 2);
    cyc("mis.c3", 0, 1, 1, 2);
    cyc("mis.c4", 0, 0, 0, 0);
    idle();
    cyc("mis.c5", 0, 0, 0, 0);

    // Flush during a load-use stall, then reload in FLUSH
    drv(1, 0, 0, 0, 0, 3, 1, 1, 0);
    cyc("fs.c0", 0, 0, 0, 0);
    drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
    cyc("fs.c1", 1, 0, 1, 0);
    drv(1, 3, 1, 0, 0, 0, 0, 0, 1);
    cyc("fs.c2", 0, 1, 1, 1);
    cyc("fs.c3", 0, 1, 1, 2);
    drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
    cyc("fs.c4", 0, 1, 1, 2);
    cyc("fs.c5", 0, 1, 1, 2);
    cyc("fs.c6", 0, 0, 0, 0);
    idle();
    cyc("fs.c7", 0, 0, 0, 0);

    // Reset in the middle of FLUSH
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("rf.c0", 0, 1, 1, 0);
    cyc("rf.c1", 0, 1, 1, 2);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    chk("rf.stall_cnt", bus.stall_cycles, 32'd0);
    chk("rf.flush_cnt", bus.flush_cycles, 32'd0);
`endif
    cyc("rf.c3", 0, 0, 0, 0);

    // Reset clears an in-flight load entry
    drv(1, 0, 0, 0, 0, 4, 1, 1, 0);
    cyc("rs.c0", 0, 0, 0, 0);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv(1, 4, 1, 0, 0, 0, 0, 0, 0);
    cyc("rs.c2", 0, 0, 0, 0);
    idle();
    cyc("rs.c3", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
